chunk_adder: RTL and testbench
==============================

# chunk_adder

Sequential, parametrised successor to the combinational ripple adder. Adds or subtracts two WIDTH-bit operands in CHUNK-bit slices, one slice per clock, so a wide word is handled by a narrow carry chain, a small one in gate count and fluidic delay. A start/busy/done handshake lets the ALU sequencer issue operations. Status flags (carry, signed overflow, zero) are produced alongside the sum.

## Interface
- WIDTH, 8, operand and result width; must be a multiple of CHUNK.
- CHUNK, 2, bits added per cycle; 1 ≤ CHUNK ≤ WIDTH; N = WIDTH/CHUNK steps.
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled on the rising edge when not busy.
- sub  in  1  0 = add, 1 = subtract; latched with start.
- ci  in  1  carry-in (add) / borrow-in (sub); latched with start.
- A  in  WIDTH  operand A; latched with start.
- B  in  WIDTH  operand B; latched with start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse, results valid.
- out  out  WIDTH  result; held until next accepted start.
- co  out  1  carry out of MSB (sub: 1 = no borrow).
- ovf  out  1  two's-complement overflow.
- zero  out  1  out == 0.

## Operation
- States: IDLE, RUN, DONE.
- Add: out = (A + B + ci) mod 2^WIDTH, co = bit WIDTH of the full sum.
- Sub: out = (A − B − ci) mod 2^WIDTH, computed as A + ~B + ~ci; co is the raw adder carry.
- Start accept (IDLE or DONE, start=1):
  - latch A → a_reg and (sub ? ~B : B) → b_reg;
  - carry ← ci ^ sub;
  - latch MSBs of A and the effective B;
  - step counter ← 0; go RUN.
- RUN, per cycle:
  - {c, s} = a_reg[CHUNK-1:0] + b_reg[CHUNK-1:0] + carry;
  - carry ← c;
  - a_reg, b_reg shift right by CHUNK;
  - s shifts into the result register from the MSB side (after N steps, slice 0 sits at bits CHUNK-1:0);
  - counter increments.
  - After step N, go DONE.
- DONE:
  - co ← carry;
  - ovf ← (A_msb == Beff_msb) && (out_msb != A_msb);
  - zero ← (out == 0);
  - done = 1 for this one state;
  - next state IDLE, unless start is accepted.
- start while busy: ignored; the in-flight operation is unaffected.
- out, co, ovf and zero change only on completion.
  - They hold their values through IDLE.
  - They are undefined to observers while busy; the bench checks them only at done.
- Reset values: busy=0, done=0, out=0, co=0, ovf=0, zero=0; state IDLE, counter 0.
- rst has priority over start and over every state; reset mid-RUN aborts the operation and no done is emitted.
- Elaboration error when WIDTH % CHUNK ≠ 0 or CHUNK > WIDTH.

## Timing
- Start sampled at edge k → busy=1 after edge k.
- Chunk steps occur on edges k+1 … k+N.
- After edge k+N: busy=0, done=1, out/co/ovf/zero valid.
- After edge k+N+1: done=0; the results stay held.
- Latency from accept to done = N cycles.
- Minimum issue interval = N+1 cycles (start asserted during DONE is accepted at that edge).
- CHUNK=WIDTH: N=1, i.e. one RUN cycle then DONE.
- Registered outputs only; no combinational path from inputs to outputs.

## Test plan
- WIDTH=8, CHUNK=2, add 0x5A + 0x3C, ci=0:
  - done 4 cycles after accept;
  - out=0x96, co=0, ovf=1, zero=0.
- Add 0xFF + 0x01, ci=0 → out=0x00, co=1, ovf=0, zero=1.
- Sub 0x10 − 0x20, ci=0 → out=0xF0, co=0. Sub 0x80 − 0x01, ci=0 → out=0x7F, co=1, ovf=1.
- Back-to-back and busy handling:
  - start held high during RUN with different operands → ignored; the first result is correct;
  - start during DONE → second operation accepted with no idle gap.
- rst asserted at step 2 of RUN:
  - next cycle busy=0, done=0, out=0, and all flags 0;
  - no done pulse follows;
  - a fresh start then completes normally.
- Random regression:
  - 256 random A/B/ci/sub per configuration, for CHUNK ∈ {1, 2, 4, 8} at WIDTH=8, plus WIDTH=16 with CHUNK=4;
  - compare {co, out}, ovf and zero against a behavioural model;
  - report the correct/total count.

Source files
------------

// File: rtl/chunk_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : chunk_adder_if
// Description : Handshake and operand/result bundle between the ALU
//               sequencer (master) and the chunked adder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface chunk_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic             ci;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic             co;
    logic             ovf;
    logic             zero;

    modport master (
        output start, sub, ci, A, B,
        input  busy, done, out, co, ovf, zero
    );

    modport slave (
        input  start, sub, ci, A, B,
        output busy, done, out, co, ovf, zero
    );
endinterface
`default_nettype wire

// File: rtl/chunk_adder.sv
`default_nettype none
// ============================================================================
// Module      : chunk_adder
// Description : Sequential add/subtract of two WIDTH-bit operands, CHUNK bits
//               per clock through a narrow carry chain, with carry, signed
//               overflow and zero flags and a start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module chunk_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic          clk,
    input  logic          rst,
    chunk_adder_if.slave  bus
);

    generate
        if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    localparam int                 c_steps = WIDTH / CHUNK;
    localparam int                 c_cnt_w = $clog2(c_steps + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(c_steps - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_carry;
    logic               r_a_msb;
    logic               r_b_msb;
    logic [c_cnt_w-1:0] r_cnt;

    logic [WIDTH-1:0]   r_out;
    logic               r_co;
    logic               r_ovf;
    logic               r_zero;

    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   w_b_eff;
    logic [CHUNK:0]     w_sum;
    logic [WIDTH-1:0]   w_res_next;

    // A new request is taken whenever no operation is in flight.
    assign w_accept = bus.start && (r_state != S_RUN);
    assign w_last   = (r_cnt == c_last);
    // Subtraction is A + ~B + ~borrow, so invert B here and ci at latch time.
    assign w_b_eff  = bus.sub ? ~bus.B : bus.B;

    // One slice of the narrow carry chain.
    assign w_sum = {1'b0, r_a[CHUNK-1:0]}
                 + {1'b0, r_b[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, r_carry};

    // Each new slice enters from the MSB side so slice 0 ends at the bottom.
    generate
        if (CHUNK == WIDTH) begin : g_res_single
            assign w_res_next = w_sum[CHUNK-1:0];
        end else begin : g_res_shift
            assign w_res_next = {w_sum[CHUNK-1:0], r_res[WIDTH-1:CHUNK]};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: RUN lasts exactly c_steps cycles, DONE one cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_RUN;
            S_RUN:   if (w_last)    w_next = S_DONE;
            S_DONE:  w_next = bus.start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand latch, per-slice stepping, and result/flag capture on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_co    <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.A;
            r_b     <= w_b_eff;
            r_carry <= bus.ci ^ bus.sub;
            r_a_msb <= bus.A[WIDTH-1];
            r_b_msb <= w_b_eff[WIDTH-1];
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> CHUNK;
            r_b     <= r_b >> CHUNK;
            r_carry <= w_sum[CHUNK];
            r_res   <= w_res_next;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_out  <= w_res_next;
                r_co   <= w_sum[CHUNK];
                r_ovf  <= (r_a_msb == r_b_msb) && (w_res_next[WIDTH-1] != r_a_msb);
                r_zero <= (w_res_next == '0);
            end
        end
    end

    assign bus.busy = (r_state == S_RUN);
    assign bus.done = (r_state == S_DONE);
    assign bus.out  = r_out;
    assign bus.co   = r_co;
    assign bus.ovf  = r_ovf;
    assign bus.zero = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_chunk_adder
// Description : Directed and randomised checks of chunk_adder at WIDTH=8 with
//               CHUNK 1/2/4/8 and at WIDTH=16 with CHUNK=4, all driven from
//               one shared stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chunk_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic        ci = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    chunk_adder_if #(.WIDTH(8))  if8_1 ();
    chunk_adder_if #(.WIDTH(8))  if8_2 ();
    chunk_adder_if #(.WIDTH(8))  if8_4 ();
    chunk_adder_if #(.WIDTH(8))  if8_8 ();
    chunk_adder_if #(.WIDTH(16)) if16_4 ();

    assign if8_1.start = start;  assign if8_1.sub = sub;  assign if8_1.ci = ci;
    assign if8_1.A = a16[7:0];   assign if8_1.B = b16[7:0];
    assign if8_2.start = start;  assign if8_2.sub = sub;  assign if8_2.ci = ci;
    assign if8_2.A = a16[7:0];   assign if8_2.B = b16[7:0];
    assign if8_4.start = start;  assign if8_4.sub = sub;  assign if8_4.ci = ci;
    assign if8_4.A = a16[7:0];   assign if8_4.B = b16[7:0];
    assign if8_8.start = start;  assign if8_8.sub = sub;  assign if8_8.ci = ci;
    assign if8_8.A = a16[7:0];   assign if8_8.B = b16[7:0];
    assign if16_4.start = start; assign if16_4.sub = sub; assign if16_4.ci = ci;
    assign if16_4.A = a16;       assign if16_4.B = b16;

    chunk_adder #(.WIDTH(8),  .CHUNK(1)) dut8_1  (.clk(clk), .rst(rst), .bus(if8_1));
    chunk_adder #(.WIDTH(8),  .CHUNK(2)) dut8_2  (.clk(clk), .rst(rst), .bus(if8_2));
    chunk_adder #(.WIDTH(8),  .CHUNK(4)) dut8_4  (.clk(clk), .rst(rst), .bus(if8_4));
    chunk_adder #(.WIDTH(8),  .CHUNK(8)) dut8_8  (.clk(clk), .rst(rst), .bus(if8_8));
    chunk_adder #(.WIDTH(16), .CHUNK(4)) dut16_4 (.clk(clk), .rst(rst), .bus(if16_4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference arithmetic: returns {zero, ovf, co, out[15:0]}.
    function automatic logic [18:0] model(input int w, input logic s, input logic c,
                                          input logic [15:0] a, input logic [15:0] b);
        longint mask, half, ua, ub, sa, sb, sr, full, o;
        logic   co_m, ovf_m;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        sa   = (ua >= half) ? ua - (longint'(1) << w) : ua;
        sb   = (ub >= half) ? ub - (longint'(1) << w) : ub;
        if (!s) begin
            full = ua + ub + longint'(c);
            o    = full & mask;
            co_m = ((full >> w) & 1) != 0;
            sr   = sa + sb + longint'(c);
        end else begin
            o    = (ua - ub - longint'(c)) & mask;
            co_m = (ua >= ub + longint'(c));
            sr   = sa - sb - longint'(c);
        end
        ovf_m = (sr >= half) || (sr < -half);
        return {(o == 0), ovf_m, co_m, o[15:0]};
    endfunction

    // Issue one request and wait for done on the CHUNK=2 instance; lat counts
    // rising edges from the accepting edge to the one that raises done.
    task automatic run_op(input logic s, input logic c, input logic [15:0] a,
                          input logic [15:0] b, output int lat);
        @(negedge clk);
        sub = s; ci = c; a16 = a; b16 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!if8_2.done && lat < 30) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic chk_primary(input string tag, input logic [7:0] o, input logic c,
                               input logic v, input logic z);
        chk({tag, "_done"}, 32'(if8_2.done), 32'd1);
        chk({tag, "_out"},  32'(if8_2.out),  32'(o));
        chk({tag, "_co"},   32'(if8_2.co),   32'(c));
        chk({tag, "_ovf"},  32'(if8_2.ovf),  32'(v));
        chk({tag, "_zero"}, 32'(if8_2.zero), 32'(z));
    endtask

    task automatic chk_all(input string tag);
        logic [18:0] e8, e16;
        e8  = model(8,  sub, ci, a16, b16);
        e16 = model(16, sub, ci, a16, b16);
        chk({tag, "_c1_sum"},  {23'd0, if8_1.co, if8_1.out}, {23'd0, e8[16:8] == 9'd0 ? e8[16] : e8[16], e8[7:0]});
        chk({tag, "_c1_flags"}, {30'd0, if8_1.ovf, if8_1.zero}, {30'd0, e8[17], e8[18]});
        chk({tag, "_c2_sum"},  {23'd0, if8_2.co, if8_2.out}, {23'd0, e8[16], e8[7:0]});
        chk({tag, "_c2_flags"}, {30'd0, if8_2.ovf, if8_2.zero}, {30'd0, e8[17], e8[18]});
        chk({tag, "_c4_sum"},  {23'd0, if8_4.co, if8_4.out}, {23'd0, e8[16], e8[7:0]});
        chk({tag, "_c4_flags"}, {30'd0, if8_4.ovf, if8_4.zero}, {30'd0, e8[17], e8[18]});
        chk({tag, "_c8_sum"},  {23'd0, if8_8.co, if8_8.out}, {23'd0, e8[16], e8[7:0]});
        chk({tag, "_c8_flags"}, {30'd0, if8_8.ovf, if8_8.zero}, {30'd0, e8[17], e8[18]});
        chk({tag, "_w16_sum"}, {15'd0, if16_4.co, if16_4.out}, {15'd0, e16[16], e16[15:0]});
        chk({tag, "_w16_flags"}, {30'd0, if16_4.ovf, if16_4.zero}, {30'd0, e16[17], e16[18]});
    endtask

    initial begin
        int lat;
        int pulses;

        // Reset state.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(if8_2.busy), 32'd0);
        chk("rst_done", 32'(if8_2.done), 32'd0);
        chk("rst_out",  32'(if8_2.out),  32'd0);
        chk("rst_co",   32'(if8_2.co),   32'd0);
        chk("rst_ovf",  32'(if8_2.ovf),  32'd0);
        chk("rst_zero", 32'(if8_2.zero), 32'd0);

        // 0x5A + 0x3C: latency 4, signed overflow into 0x96.
        @(negedge clk);
        sub = 1'b0; ci = 1'b0; a16 = 16'h005A; b16 = 16'h003C; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("add1_busy_after_accept", 32'(if8_2.busy), 32'd1);
        lat = 0;
        while (!if8_2.done && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        chk("add1_latency", 32'(lat), 32'd4);
        chk("add1_busy_at_done", 32'(if8_2.busy), 32'd0);
        chk_primary("add1", 8'h96, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("add1_done_pulse_ends", 32'(if8_2.done), 32'd0);
        chk("add1_out_held", 32'(if8_2.out), 32'h96);
        repeat (6) @(negedge clk);
        chk_all("add1");

        // 0xFF + 0x01: wraps to zero with carry out.
        run_op(1'b0, 1'b0, 16'h00FF, 16'h0001, lat);
        chk_primary("add2", 8'h00, 1'b1, 1'b0, 1'b1);

        // 0x10 - 0x20: borrow, so co = 0.
        run_op(1'b1, 1'b0, 16'h0010, 16'h0020, lat);
        chk_primary("sub1", 8'hF0, 1'b0, 1'b0, 1'b0);

        // 0x80 - 0x01: no borrow, signed overflow.
        run_op(1'b1, 1'b0, 16'h0080, 16'h0001, lat);
        chk_primary("sub2", 8'h7F, 1'b1, 1'b1, 1'b0);
        repeat (6) @(negedge clk);

        // start held high during RUN with other operands is ignored.
        @(negedge clk);
        sub = 1'b0; ci = 1'b0; a16 = 16'h0012; b16 = 16'h0034; start = 1'b1;
        @(negedge clk);
        sub = 1'b1; a16 = 16'h0077; b16 = 16'h0011;
        repeat (3) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk_primary("busy_ign", 8'h46, 1'b0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);

        // start during DONE: second op accepted with no idle gap.
        run_op(1'b0, 1'b1, 16'h0001, 16'h0002, lat);
        chk_primary("b2b_first", 8'h04, 1'b0, 1'b0, 1'b0);
        sub = 1'b1; ci = 1'b0; a16 = 16'h0080; b16 = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy_after_done", 32'(if8_2.busy), 32'd1);
        chk("b2b_done_low", 32'(if8_2.done), 32'd0);
        repeat (3) @(negedge clk);
        chk("b2b_not_yet_done", 32'(if8_2.done), 32'd0);
        @(negedge clk);
        chk_primary("b2b_second", 8'h7F, 1'b1, 1'b1, 1'b0);
        repeat (10) @(negedge clk);

        // Reset during step 2 aborts the operation and clears outputs.
        @(negedge clk);
        sub = 1'b0; ci = 1'b0; a16 = 16'h0033; b16 = 16'h0044; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstrun_busy", 32'(if8_2.busy), 32'd0);
        chk("rstrun_done", 32'(if8_2.done), 32'd0);
        chk("rstrun_out",  32'(if8_2.out),  32'd0);
        chk("rstrun_flags", {29'd0, if8_2.co, if8_2.ovf, if8_2.zero}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (if8_2.done) pulses++;
        end
        chk("rstrun_no_done", 32'(pulses), 32'd0);
        run_op(1'b0, 1'b0, 16'h0033, 16'h0044, lat);
        chk("rstrun_fresh_latency", 32'(lat), 32'd4);
        chk_primary("rstrun_fresh", 8'h77, 1'b0, 1'b0, 1'b0);
        repeat (6) @(negedge clk);

        // Randomised operands across all configurations.
        for (int n = 0; n < 256; n++) begin
            run_op(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), lat);
            chk("rand_latency", 32'(lat), 32'd4);
            repeat (6) @(negedge clk);
            chk_all("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
